uart_tx_fifo: RTL and testbench

Transmit-side buffer sitting directly upstream of the uart block. It accepts bytes from the CPU/MMIO side over a valid/ready handshake and stores them in a circular FIFO. It drains them one at a time into the uart's i_valid/i_data/tx_done interface. This lets software burst-write strings without polling tx_done per byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo_checker.sv | 25 ++
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: byte width and the
// launch FSM state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular register-array FIFO with push/pop/flush and an explicit level
// counter; reusable on either side of the uart.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_s   = (level_r == (AW+1)'(0));
  assign full_s    = (level_r == (AW+1)'(DEPTH));
  // Flush wins over both a same-cycle push and a same-cycle pop.
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty_s && !flush;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers, wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= (AW+1)'(0);
    end else if (flush) begin
      level_r <= (AW+1)'(0);
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign level    = level_r;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: rtl/uart_tx_fifo_checker.sv
// Simulation-time invariants for the transmit buffer: no read from an
// empty FIFO, no growth past DEPTH, no write while full.
module uart_tx_fifo_checker #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst_n,
  input logic        launch,
  input logic        flush,
  input logic        empty,
  input logic        full,
  input logic [AW:0] level
);

  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
    launch |-> !empty);

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= (AW+1)'(DEPTH));

  a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
    (full && !launch && !flush) |=> full);

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the uart: queues CPU bytes and launches them
// one at a time, waiting for tx_done to drop and recover between bytes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              uart_valid,
  output logic [BYTE_W-1:0] uart_data,
  input  logic              uart_done,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  tx_state_e         state_r;
  tx_state_e         next_state_s;
  logic              launch_s;
  logic              uart_valid_r;
  logic [BYTE_W-1:0] uart_data_r;
  logic [BYTE_W-1:0] pop_data_s;
  logic [AW:0]       level_s;
  logic              empty_s;
  logic              full_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (launch_s),
    .pop_data  (pop_data_s),
    .flush     (flush),
    .level     (level_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Launch FSM next-state; WAIT_BUSY masks the stale tx_done right after launch.
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && uart_done && !flush) begin
          launch_s     = 1'b1;
          next_state_s = LAUNCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      LAUNCH: begin
        next_state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!uart_done) begin
          next_state_s = WAIT_DONE;
        end else begin
          next_state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (uart_done) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register; flush leaves it alone so an in-flight byte finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered uart launch pulse and held data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_valid_r <= 1'b0;
      uart_data_r  <= 8'h00;
    end else begin
      uart_valid_r <= launch_s;
      if (launch_s) begin
        uart_data_r <= pop_data_s;
      end else begin
        uart_data_r <= uart_data_r;
      end
    end
  end

  uart_tx_fifo_checker #(
    .DEPTH (DEPTH)
  ) u_checker (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (launch_s),
    .flush  (flush),
    .empty  (empty_s),
    .full   (full_s),
    .level  (level_s)
  );

  assign wr_ready   = !full_s;
  assign uart_valid = uart_valid_r;
  assign uart_data  = uart_data_r;
  assign level      = level_s;
  assign empty      = empty_s;
  assign full       = full_s;
  assign busy       = (state_r != IDLE) || !empty_s || !uart_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo with a behavioural uart
// model and a queue-based scoreboard of the bytes expected on the line.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int CLK_DIV = 2;
  localparam int TX_CYC  = 10 * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          hold_low = 1'b0;
  logic          wr_ready;
  logic          uart_valid;
  logic [7:0]    uart_data;
  logic          uart_done;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          busy;

  logic          model_busy;
  int            model_cnt;

  logic [7:0]    ref_q[$];
  logic          prev_valid;
  int            n_launch = 0;
  int            n_acc = 0;
  int            n_flushed = 0;
  int            mon_bad = 0;

  int            n_checks = 0;
  int            n_fail = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_done  (uart_done),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign uart_done = !model_busy && !hold_low;

  // uart model: latches on i_valid, tx_done low for TX_CYC cycles afterwards
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (!model_busy) begin
      if (uart_valid) begin
        model_busy <= 1'b1;
        model_cnt  <= TX_CYC;
      end
    end else if (model_cnt <= 1) begin
      model_busy <= 1'b0;
    end else begin
      model_cnt <= model_cnt - 1;
    end
  end

  // scoreboard: bytes accepted in FIFO order, checked at each observed launch
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q.delete();
      prev_valid <= 1'b0;
    end else begin
      if (uart_valid) begin
        if (prev_valid || model_busy || ref_q.size() == 0 || uart_data !== ref_q[0])
          mon_bad <= mon_bad + 1;
        if (ref_q.size() != 0) ref_q.delete(0);
        n_launch <= n_launch + 1;
      end
      if (flush) begin
        n_flushed <= n_flushed + ref_q.size();
        ref_q.delete();
      end else if (wr_valid && ref_q.size() < DEPTH) begin
        ref_q.push_back(wr_data);
        n_acc <= n_acc + 1;
      end
      prev_valid <= uart_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%0b required 0 within 3000 cycles", name, busy);
    end
  endtask

  task automatic test_reset();
    int pulses;
    #1 rst_n = 1'b0;
    #3;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %0b want 1", wr_ready); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b want 0", full); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %0h want 00", uart_data); end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (uart_valid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL idle_level: got %0d want 0", level); end
  endtask

  task automatic test_single();
    int l0 = n_launch;
    write_byte(8'h41);
    n_checks++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: uart_valid=%0b want 0", uart_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b want 1", busy); end
    tick();
    n_checks++; if (uart_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: uart_valid=%0b want 1", uart_valid); end
    n_checks++; if (uart_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %0h want 41", uart_data); end
    tick();
    n_checks++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: uart_valid=%0b want 0", uart_valid); end
    wait_idle("single");
    n_checks++; if (n_launch - l0 != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", n_launch - l0); end
    n_checks++; if (uart_data !== 8'h41) begin n_fail++; $display("FAIL single_hold: got %0h want 41", uart_data); end
  endtask

  task automatic test_burst();
    logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int l0 = n_launch;
    for (int i = 0; i < 5; i++) write_byte(msg[i]);
    wait_idle("burst");
    n_checks++; if (n_launch - l0 != 5) begin n_fail++; $display("FAIL burst_count: got %0d want 5", n_launch - l0); end
    n_checks++; if (uart_data !== 8'h6F) begin n_fail++; $display("FAIL burst_last: got %0h want 6f", uart_data); end
    n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL burst_scoreboard: %0d bad launches want 0", mon_bad); end
  endtask

  task automatic test_fill();
    for (int r = 0; r < 2; r++) begin
      int l0 = n_launch;
      hold_low = 1'b1;
      for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
      n_checks++; if (full !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: full=%0b wr_ready=%0b want 1/0", full, wr_ready); end
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d want 16", level); end
      write_byte(8'hEE);
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_overflow: got %0d want 16", level); end
      hold_low = 1'b0;
      wait_idle("fill");
      n_checks++; if (n_launch - l0 != DEPTH) begin n_fail++; $display("FAIL fill_drain_count: got %0d want %0d", n_launch - l0, DEPTH); end
      n_checks++; if (empty !== 1'b1 || level !== 5'd0) begin n_fail++; $display("FAIL fill_empty: empty=%0b level=%0d want 1/0", empty, level); end
    end
    n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL fill_scoreboard: %0d bad launches want 0", mon_bad); end
  endtask

  task automatic test_simultaneous();
    int l0 = n_launch;
    hold_low = 1'b1;
    write_byte(8'hA1);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL simul_pre: level=%0d want 1", level); end
    hold_low = 1'b0;
    write_byte(8'hB2);
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL simul_level1: level=%0d want 1", level); end
    wait_idle("simul1");
    n_checks++; if (n_launch - l0 != 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", n_launch - l0); end
    n_checks++; if (uart_data !== 8'hB2) begin n_fail++; $display("FAIL simul_next: got %0h want b2", uart_data); end
    l0 = n_launch;
    hold_low = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    hold_low = 1'b0;
    write_byte(8'h77);
    n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL simul_full: level=%0d want 15", level); end
    wait_idle("simul2");
    n_checks++; if (n_launch - l0 != DEPTH) begin n_fail++; $display("FAIL simul_full_count: got %0d want %0d", n_launch - l0, DEPTH); end
    n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL simul_scoreboard: %0d bad launches want 0", mon_bad); end
  endtask

  task automatic test_flush();
    int l0 = n_launch;
    for (int i = 0; i < 6; i++) write_byte(8'h30 + 8'(i));
    n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL flush_pre: level=%0d want 5", level); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (level !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear: level=%0d empty=%0b want 0/1", level, empty); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: busy=%0b want 1", busy); end
    wait_idle("flush");
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (n_launch - l0 != 1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", n_launch - l0); end
    flush = 1'b1;
    write_byte(8'h99);
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (level !== 5'd0 || n_launch - l0 != 1) begin n_fail++; $display("FAIL flush_write_drop: level=%0d launches=%0d want 0/1", level, n_launch - l0); end
    n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL flush_scoreboard: %0d bad launches want 0", mon_bad); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i));
    for (int i = 0; i < 20 && !model_busy; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL arst_fifo: level=%0d empty=%0b full=%0b wr_ready=%0b want 0/1/0/1", level, empty, full, wr_ready); end
    n_checks++; if (busy !== 1'b0 || uart_valid !== 1'b0 || uart_data !== 8'h00) begin n_fail++; $display("FAIL arst_out: busy=%0b valid=%0b data=%0h want 0/0/00", busy, uart_valid, uart_data); end
    #3 rst_n = 1'b1;
    tick();
    write_byte(8'h5A);
    tick();
    n_checks++; if (uart_valid !== 1'b1) begin n_fail++; $display("FAIL arst_launch: uart_valid=%0b want 1", uart_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (uart_valid !== 1'b0 || uart_data !== 8'h00) begin n_fail++; $display("FAIL arst_valid_drop: valid=%0b data=%0h want 0/00", uart_valid, uart_data); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int l0 = n_launch;
    int a0 = n_acc;
    int f0 = n_flushed;
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_data  = 8'($urandom);
      flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) hold_low = !hold_low;
      tick();
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    hold_low = 1'b0;
    wait_idle("random");
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL random_level: got %0d want 0", level); end
    n_checks++; if (n_launch - l0 != (n_acc - a0) - (n_flushed - f0)) begin n_fail++; $display("FAIL random_count: launches=%0d want %0d", n_launch - l0, (n_acc - a0) - (n_flushed - f0)); end
    n_checks++; if (mon_bad != 0) begin n_fail++; $display("FAIL random_scoreboard: %0d bad launches want 0", mon_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
